dmx_scan_ctrl: RTL and testbench
================================

Name: dmx_scan_ctrl

Overview:
- Round-robin slot scheduler for the 1-to-8 single-bit demultiplexer path.
- Accepts a serial bit stream over a valid/ready handshake and steps the demux address across the enabled output channels.
- Holds each channel for a programmable dwell and drives the decoded, registered one-hot-gated output word.
- Sits between a serial source and eight per-channel sinks.

Parameters:
- N_CH, 8, number of output channels; fixed at 8 for this revision.
- ADDR_W, 3, channel address width (log2 of N_CH).
- DWELL_W, 8, width of the dwell count input.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scheduler enable.
- ch_mask  input  8  per-channel enable; bit i set means channel i takes part in the scan.
- dwell  input  DWELL_W  slot length in cycles; value 0 is treated as 1.
- in_valid  input  1  source has a bit.
- in_data  input  1  serial data bit.
- in_ready  output  1  block accepts in_data this cycle.
- addr  output  ADDR_W  currently selected channel (registered).
- out_data  output  8  demuxed data, registered.
- slot_start  output  1  one-cycle pulse on the first DWELL cycle of each slot.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, addr=0, out_data=0, slot_start=0, in_ready=0, busy=0, internal ptr=0, cnt=0, dwell_q=1.
- States: IDLE, SEEK, DWELL.
- IDLE:
  - If en=1 and ch_mask!=0, go to SEEK; otherwise stay.
  - out_data<=0.
- SEEK (exactly 1 cycle):
  - Find the first set bit of ch_mask at or after ptr, wrapping 7->0.
  - addr<=found; cnt<=0; dwell_q<=max(dwell,1); out_data<=0; go to DWELL; slot_start=1 in the next cycle.
  - If en=0 or ch_mask=0 in SEEK, go to IDLE instead; addr is unchanged.
- DWELL:
  - in_ready = (state==DWELL) && en, which is combinational from registered state.
  - Transfer when in_valid && in_ready. out_data<=transfer ? (in_data<<addr) : 0, so latency is 1 cycle and at most one bit is set.
  - cnt increments each DWELL cycle.
  - When cnt==dwell_q-1: ptr<=(addr+1) mod 8 and go to SEEK.
  - If en=0 in DWELL: abort the slot, go to IDLE next cycle, ptr<=(addr+1) mod 8, and accept no transfer that cycle.
- ch_mask and dwell are sampled only in SEEK. Changes mid-slot take effect at the next SEEK; a channel masked mid-slot completes its slot.
- Single enabled channel: the same channel is reselected every slot, with a 1-cycle SEEK gap (in_ready=0) between slots.
- Slot period is dwell_q+1 cycles: dwell_q DWELL cycles plus 1 SEEK cycle.
- addr changes only on the SEEK->DWELL edge and is stable through each DWELL period.
- Reset asserted mid-slot: all outputs return to reset values immediately (asynchronously); the scan restarts from channel 0.

Optional Feature:
- Macro DMX_SCAN_EARLY_EXIT_EN.
- When defined: in DWELL, if in_valid=0 while cnt>=1, end the slot early (go to SEEK, ptr<=addr+1). This skips idle channels quickly. A slot always lasts at least 1 DWELL cycle.
- When undefined: slots always last the full dwell_q cycles regardless of in_valid.

Test Plan:
- Reset, then en=1, ch_mask=8'hFF, dwell=2, in_valid=1, in_data=1 -> addr sequence 0,1,...,7,0; each held 2 cycles with a 1-cycle SEEK gap; out_data = 8'h01, 8'h02, ... one cycle after each accept; slot_start pulses every 3 cycles.
- ch_mask=8'b1000_0100, dwell=3 -> addr alternates 2,7,2; out_data bits 2 and 7 only; no other bit ever set.
- dwell=0, ch_mask=8'h01 -> addr stays 0; in_ready toggles 1,0,1,0; period 2 cycles.
- Mid-slot on channel 5: en=0 -> next cycle IDLE, in_ready=0, busy=0, out_data=0. en=1 again -> next slot selects channel 6.
- rst_n pulsed low during DWELL with addr=4 -> addr=0, out_data=0, busy=0 within the same cycle. After release, the first slot is channel 0.
- ch_mask=0 with en=1 -> block stays in IDLE, in_ready=0. Set ch_mask=8'h10 -> SEEK, then addr=4. With DMX_SCAN_EARLY_EXIT_EN defined, dwell=10 and in_valid=0 -> each slot lasts 2 DWELL cycles.

Source files
------------

// File: rtl/dmx_scan_ctrl.sv
// Round-robin slot scheduler for the 1-to-8 single-bit demux path: steps addr over enabled channels
// and holds each one for a programmable dwell. Optional macro DMX_SCAN_EARLY_EXIT_EN ends idle slots early.
module dmx_scan_ctrl #(
  parameter int N_CH    = 8,
  parameter int ADDR_W  = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               in_valid,
  input  logic               in_data,
  output logic               in_ready,
  output logic [ADDR_W-1:0]  addr,
  output logic [N_CH-1:0]    out_data,
  output logic               slot_start,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  // Handshake: a bit transfers on any cycle with in_valid && in_ready; in_ready is
  // high only in DWELL while en is high, and never depends on in_valid.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;

  logic [ADDR_W-1:0]  next_ch;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W-1:0]  addr_inc;
  logic [DWELL_W-1:0] dwell_eff;
  logic [N_CH-1:0]    data_word;
  logic               xfer;
  logic               early_exit;
  logic               slot_end;

  // Rotating priority search: walk from the farthest offset down so the
  // nearest enabled channel at or after ptr wins. ADDR_W bits wrap 7->0.
  always_comb begin
    next_ch = ptr;
    idx     = ptr;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = ptr + ADDR_W'(k);
      if (ch_mask[idx]) next_ch = idx;
    end
  end

  assign addr_inc  = addr + ADDR_W'(1);
  assign dwell_eff = (dwell == '0) ? DWELL_ONE : dwell;
  assign data_word = {{(N_CH-1){1'b0}}, in_data} << addr;

  assign in_ready  = (state == DWELL) && en;
  assign xfer      = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

`ifdef DMX_SCAN_EARLY_EXIT_EN
  // After the first DWELL cycle, a quiet source ends the slot so idle channels are skipped.
  assign early_exit = !in_valid && (cnt != '0);
`else
  assign early_exit = 1'b0;
`endif

  assign slot_end = (cnt == (dwell_q - DWELL_ONE)) || early_exit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      out_data   <= '0;
      slot_start <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
      dwell_q    <= DWELL_ONE;
    end else begin
      slot_start <= 1'b0;
      case (state)
        IDLE: begin
          out_data <= '0;
          if (en && (ch_mask != '0)) state <= SEEK;
        end
        SEEK: begin
          out_data <= '0;
          if (!en || (ch_mask == '0)) begin
            state <= IDLE;
          end else begin
            addr       <= next_ch;
            cnt        <= '0;
            dwell_q    <= dwell_eff;
            slot_start <= 1'b1;
            state      <= DWELL;
          end
        end
        DWELL: begin
          if (!en) begin
            // Abort: the slot is abandoned but the scan resumes after this channel.
            out_data <= '0;
            ptr      <= addr_inc;
            state    <= IDLE;
          end else begin
            out_data <= xfer ? data_word : '0;
            cnt      <= cnt + DWELL_W'(1);
            if (slot_end) begin
              ptr   <= addr_inc;
              state <= SEEK;
            end
          end
        end
        default: begin
          out_data <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmx_scan_ctrl.sv
// Self-checking bench for dmx_scan_ctrl: directed test-plan steps plus randomized traffic,
// compared every cycle against a slot-level behavioural model.
module tb_dmx_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] ch_mask;
  logic [7:0] dwell;
  logic       in_valid;
  logic       in_data;
  logic       in_ready;
  logic [2:0] addr;
  logic [7:0] out_data;
  logic       slot_start;
  logic       busy;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  dmx_scan_ctrl #(.N_CH(8), .ADDR_W(3), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ch_mask    (ch_mask),
    .dwell      (dwell),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .addr       (addr),
    .out_data   (out_data),
    .slot_start (slot_start),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase of the scan plus remaining slot length
  localparam int P_IDLE = 0, P_SEEK = 1, P_SLOT = 2;
  int         m_phase;
  logic [2:0] m_addr;
  logic [2:0] m_ptr;
  logic [7:0] m_out;
  bit         m_ss;
  int         m_left;
  int         m_used;

  function automatic void model_reset();
    m_phase = P_IDLE;
    m_addr  = 3'd0;
    m_ptr   = 3'd0;
    m_out   = 8'h00;
    m_ss    = 1'b0;
    m_left  = 1;
    m_used  = 0;
  endfunction

  function automatic void model_next();
    bit exit_now;
    bit found;
    m_ss = 1'b0;
    case (m_phase)
      P_IDLE: begin
        m_out = 8'h00;
        if (en && ch_mask != 8'h00) m_phase = P_SEEK;
      end
      P_SEEK: begin
        m_out = 8'h00;
        if (!en || ch_mask == 8'h00) begin
          m_phase = P_IDLE;
        end else begin
          found = 1'b0;
          for (int k = 0; k < 8; k++) begin
            if (!found && ch_mask[(m_ptr + k) % 8]) begin
              m_addr = 3'((m_ptr + k) % 8);
              found  = 1'b1;
            end
          end
          m_left  = (dwell == 8'd0) ? 1 : int'(dwell);
          m_used  = 0;
          m_ss    = 1'b1;
          m_phase = P_SLOT;
        end
      end
      default: begin
        if (!en) begin
          m_out   = 8'h00;
          m_ptr   = 3'((m_addr + 1) % 8);
          m_phase = P_IDLE;
        end else begin
          m_out  = (in_valid && in_data) ? 8'(1 << m_addr) : 8'h00;
          m_used = m_used + 1;
          m_left = m_left - 1;
          exit_now = (m_left == 0);
`ifdef DMX_SCAN_EARLY_EXIT_EN
          if (!in_valid && m_used >= 2) exit_now = 1'b1;
`endif
          if (exit_now) begin
            m_ptr   = 3'((m_addr + 1) % 8);
            m_phase = P_SEEK;
          end
        end
      end
    endcase
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("addr",       32'(addr),       32'(m_addr));
    chk("out_data",   32'(out_data),   32'(m_out));
    chk("slot_start", 32'(slot_start), 32'(m_ss));
    chk("busy",       32'(busy),       32'(m_phase != P_IDLE));
    chk("in_ready",   32'(in_ready),   32'(m_phase == P_SLOT && en));
  endtask

  // Driver: inputs are already set; advance model and DUT one cycle and compare
  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit hit;
    rst_n    = 1'b0;
    en       = 1'b0;
    ch_mask  = 8'h00;
    dwell    = 8'd0;
    in_valid = 1'b0;
    in_data  = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Full mask, dwell 2, constant ones
    en = 1'b1; ch_mask = 8'hFF; dwell = 8'd2; in_valid = 1'b1; in_data = 1'b1;
    run(2);
    chk("first_slot_addr", 32'(addr), 32'd0);
    chk("first_slot_pulse", 32'(slot_start), 32'd1);
    run(26);

    // Two channels, dwell 3
    ch_mask = 8'b1000_0100; dwell = 8'd3;
    run(20);

    // Single channel, dwell 0
    ch_mask = 8'h01; dwell = 8'd0;
    run(12);

    // Abort mid-slot on channel 5
    ch_mask = 8'hFF; dwell = 8'd4;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      if (m_phase == P_SLOT && m_addr == 3'd5) hit = 1'b1;
    end
    chk("reach_ch5", 32'(hit), 32'd1);
    en = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out", 32'(out_data), 32'd0);
    en = 1'b1;
    run(2);
    chk("resume_ch6", 32'(addr), 32'd6);
    run(4);

    // Asynchronous reset mid-slot on channel 4
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      if (m_phase == P_SLOT && m_addr == 3'd4) hit = 1'b1;
    end
    chk("reach_ch4", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_out", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(2);
    chk("post_rst_ch0", 32'(addr), 32'd0);
    run(6);

    // Empty mask keeps the block idle; then a single channel 4
    ch_mask = 8'h00;
    run(6);
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_ready", 32'(in_ready), 32'd0);
    ch_mask = 8'h10;
    run(2);
    chk("mask10_addr", 32'(addr), 32'd4);
    dwell = 8'd10; in_valid = 1'b0;
    run(30);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) ch_mask = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) dwell = 8'($urandom_range(0, 5));
      if (en && $urandom_range(0, 24) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
